pc_flags_unit: RTL and testbench
================================

Name: pc_flags_unit

Overview:
- Sequential upstream stage of the top control ROM: holds the 8-bit program counter and the 4-bit NZVC flags register, which together form that ROM's 12-bit address.
- Consumes the ROM's PCincr decode: increment the PC, or load the jump target from the instruction's immediate field.
- Latches ALU flags and adds run/stop/single-step control plus a retired-instruction counter for debug.

Parameters:
COUNT_WIDTH, 16, width of the retired-instruction counter (saturating)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
PCincr  input  1  from top ROM: 1 = PC+1, 0 = load jump_addr
jump_addr  input  8  jump target (instruction immediate)
flags_in  input  4  ALU flags {N,Z,V,C}
flags_load  input  1  1 = latch flags_in on an advancing cycle
run_en  input  1  level: free-run request
step_req  input  1  four-phase single-step request
PC  output  8  program counter to top ROM address [7:0]
NZVC  output  4  flags register to top ROM address [11:8]
running  output  1  1 while in RUN
step_ack  output  1  four-phase single-step acknowledge
halted  output  1  jump-to-self detected (see Optional Feature)
instr_count  output  COUNT_WIDTH  instructions retired since reset

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (clk, reset). On assertion, immediately: PC=8'h00, NZVC=4'h0, instr_count=0, state=IDLE, running=0, step_ack=0, halted=0. Reset mid-step or mid-run aborts with no partial update.
- States:
  - IDLE: no advance. run_en=1 -> RUN, else step_req=1 -> STEP. run_en has priority.
  - RUN: running=1.
  - STEP: exactly one advance. Next state ACK.
  - ACK: step_ack=1. step_req=0 -> IDLE.
  - HALT: only with the optional feature.
- RUN exit: if run_en=0 -> IDLE at the next edge.
- advance = (state==RUN && run_en) || state==STEP. It is combinational; all register updates occur at the edge.
- On an advancing edge:
  - PC <= PCincr ? PC+1 : jump_addr. PC+1 wraps 8'hFF -> 8'h00.
  - If flags_load, NZVC <= flags_in; otherwise flags hold.
  - instr_count increments; it saturates at all-ones, with no wrap.
- Non-advancing cycles: PC, NZVC and instr_count hold.
- Latency: PC/NZVC change one edge after advance. The top ROM sees the new address in the following cycle; the whole unit is single-cycle per instruction.
- step_req held high through ACK produces no second step; a new step requires step_req low first.
- run_en rising while in ACK is ignored until IDLE is reached.
- All outputs are registered, except that running and step_ack are decoded from state registers.

Optional Feature:
Macro HALT_DETECT_EN.
- Defined:
  - On an advancing edge with PCincr=0 and jump_addr==PC, PC reloads its own value, and the state goes to HALT instead of its normal next state. halted=1 and running=0.
  - HALT has no advance, ignores run_en and step_req, and exits only via reset.
  - instr_count counts the halting instruction.
  - If that edge is a STEP, the state goes to HALT, not ACK, and step_ack stays 0.
- Undefined:
  - halted is tied to 0 and the HALT state does not exist.
  - A jump-to-self simply loops: PC is unchanged and instr_count keeps incrementing in RUN.

Test Plan:
1. Reset, run_en=1, PCincr=1 for 5 cycles -> PC 00,01,02,03,04,05 on successive edges; instr_count=5; running=1.
2. PC=8'hFF, advance with PCincr=1 -> PC=8'h00. Then PCincr=0, jump_addr=8'h3C -> PC=8'h3C.
3. flags_in=4'b1010: flags_load=1 on an advance -> NZVC=1010. Next advance with flags_load=0 and flags_in=0101 -> NZVC stays 1010. With run_en=0 (IDLE), flags_load=1 -> no change.
4. IDLE at PC=8'h10; raise step_req and hold high 6 cycles -> PC=8'h11 only, step_ack=1 from edge 2. Drop step_req -> step_ack=0 and IDLE. Re-raise -> PC=8'h12.
5. Assert reset asynchronously mid-RUN at PC=8'h40 between edges -> PC=0, NZVC=0, instr_count=0, running=0 without waiting for clk.
6. HALT_DETECT_EN:
   - Defined: RUN at PC=8'h20, PCincr=0, jump_addr=8'h20 -> halted=1 after the edge, running=0, PC stays 20 despite run_en=1.
   - Undefined: halted=0 and instr_count increments every cycle.
   - COUNT_WIDTH=4 run: instr_count saturates at 4'hF.

Source files
------------

// File: rtl/pc_flags_unit.sv
// pc_flags_unit
//   Sequential stage ahead of the top control ROM. Holds the 8-bit program
//   counter and the NZVC flags register; together they form the ROM's 12-bit
//   address {NZVC, PC}. Adds run / stop / single-step control and a saturating
//   retired-instruction counter for debug.
//
//   Optional feature macro: HALT_DETECT_EN
//     defined   : a jump-to-self on an advancing edge parks the unit in HALT
//                 (left only through reset); halted=1.
//     undefined : halted is tied to 0 and a jump-to-self simply loops.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   PCincr       in   1 = PC+1, 0 = load jump_addr
//   jump_addr    in   [7:0] jump target (instruction immediate)
//   flags_in     in   [3:0] ALU flags {N,Z,V,C}
//   flags_load   in   latch flags_in on an advancing edge
//   run_en       in   level, free-run request
//   step_req     in   four-phase single-step request
//   PC           out  [7:0] program counter (ROM address [7:0])
//   NZVC         out  [3:0] flags register (ROM address [11:8])
//   running      out  1 while in RUN
//   step_ack     out  four-phase single-step acknowledge
//   halted       out  jump-to-self detected
//   instr_count  out  [COUNT_WIDTH-1:0] instructions retired since reset
module pc_flags_unit #(
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   PCincr,
    input  logic [7:0]             jump_addr,
    input  logic [3:0]             flags_in,
    input  logic                   flags_load,
    input  logic                   run_en,
    input  logic                   step_req,
    output logic [7:0]             PC,
    output logic [3:0]             NZVC,
    output logic                   running,
    output logic                   step_ack,
    output logic                   halted,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

`ifdef HALT_DETECT_EN
    typedef enum logic [2:0] {IDLE, RUN, STEP, ACK, HALT} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, STEP, ACK} state_t;
`endif

    state_t state, state_next;
    logic   advance;

    assign advance  = ((state == RUN) && run_en) || (state == STEP);
    assign running  = (state == RUN);
    assign step_ack = (state == ACK);

`ifdef HALT_DETECT_EN
    logic self_jump;
    logic halted_q;

    assign self_jump = advance && !PCincr && (jump_addr == PC);
    assign halted    = halted_q;
`else
    assign halted    = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (run_en)        state_next = RUN;
                else if (step_req) state_next = STEP;
            end
            RUN:  if (!run_en)     state_next = IDLE;
            STEP:                  state_next = ACK;
            ACK:  if (!step_req)   state_next = IDLE;
            default:               state_next = state;
        endcase
`ifdef HALT_DETECT_EN
        // A jump-to-self overrides whatever the normal successor would be,
        // including ACK after a single step.
        if (self_jump) state_next = HALT;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

`ifdef HALT_DETECT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= (state_next == HALT);
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PC          <= '0;
            NZVC        <= '0;
            instr_count <= '0;
        end else if (advance) begin
            PC <= PCincr ? PC + 8'd1 : jump_addr;
            if (flags_load) begin
                NZVC <= flags_in;
            end
            if (instr_count != '1) begin
                instr_count <= instr_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pc_flags_unit.sv
module tb_pc_flags_unit;

    localparam int unsigned CW      = 4;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          PCincr;
    logic [7:0]    jump_addr;
    logic [3:0]    flags_in;
    logic          flags_load;
    logic          run_en;
    logic          step_req;
    logic [7:0]    PC;
    logic [3:0]    NZVC;
    logic          running;
    logic          step_ack;
    logic          halted;
    logic [CW-1:0] instr_count;

    pc_flags_unit #(.COUNT_WIDTH(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .PCincr      (PCincr),
        .jump_addr   (jump_addr),
        .flags_in    (flags_in),
        .flags_load  (flags_load),
        .run_en      (run_en),
        .step_req    (step_req),
        .PC          (PC),
        .NZVC        (NZVC),
        .running     (running),
        .step_ack    (step_ack),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pc;
        int nzvc;
        int cnt;
        int running;
        int step_ack;
        int halted;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: mode 0 idle, 1 free-running, 2 one step owed,
    // 3 step done / awaiting request release, 4 parked after jump-to-self.
    int m_pc, m_nzvc, m_cnt, m_mode;

    function automatic void check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic void model_reset();
        m_pc = 0; m_nzvc = 0; m_cnt = 0; m_mode = 0;
    endfunction

    function automatic void model_edge();
        bit adv;
        int nxt;
        adv = (m_mode == 1 && run_en) || m_mode == 2;
        case (m_mode)
            0: nxt = run_en ? 1 : (step_req ? 2 : 0);
            1: nxt = run_en ? 1 : 0;
            2: nxt = 3;
            3: nxt = step_req ? 3 : 0;
            default: nxt = m_mode;
        endcase
`ifdef HALT_DETECT_EN
        if (adv && !PCincr && int'(jump_addr) == m_pc) nxt = 4;
`endif
        if (adv) begin
            m_pc = PCincr ? (m_pc + 1) % 256 : int'(jump_addr);
            if (flags_load) m_nzvc = int'(flags_in);
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end
        m_mode = nxt;
    endfunction

    function automatic void push_expect();
        exp_t e;
        e.pc       = m_pc;
        e.nzvc     = m_nzvc;
        e.cnt      = m_cnt;
        e.running  = (m_mode == 1) ? 1 : 0;
        e.step_ack = (m_mode == 3) ? 1 : 0;
        e.halted   = (m_mode == 4) ? 1 : 0;
        sb.push_back(e);
    endfunction

    // Monitor: the unit presents a fresh result every edge; compare 1 ns later.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("PC",          int'(PC),          e.pc);
            check("NZVC",        int'(NZVC),        e.nzvc);
            check("instr_count", int'(instr_count), e.cnt);
            check("running",     int'(running),     e.running);
            check("step_ack",    int'(step_ack),    e.step_ack);
            check("halted",      int'(halted),      e.halted);
        end
    end

    // Called with inputs stable, between edges; ends 3 ns after the edge.
    task automatic cycle(input logic inc, input logic [7:0] ja, input logic [3:0] fi,
                         input logic fl, input logic re, input logic sr);
        PCincr = inc; jump_addr = ja; flags_in = fi; flags_load = fl;
        run_en = re; step_req = sr;
        model_edge();
        push_expect();
        @(posedge clk);
        #3;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_PC",          int'(PC),          0);
        check("rst_NZVC",        int'(NZVC),        0);
        check("rst_instr_count", int'(instr_count), 0);
        check("rst_running",     int'(running),     0);
        check("rst_step_ack",    int'(step_ack),    0);
        check("rst_halted",      int'(halted),      0);
        model_reset();
        @(posedge clk);
        #3;
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        logic re_r, sr_r;
        reset = 1'b0; PCincr = 1'b1; jump_addr = '0; flags_in = '0;
        flags_load = 1'b0; run_en = 1'b0; step_req = 1'b0;
        #3;
        do_reset();

        // Free run from reset: one edge to enter RUN, then five increments.
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0);
        check("t1_PC", int'(PC), 5);
        check("t1_count", int'(instr_count), 5);
        check("t1_running", int'(running), 1);

        // Wrap and jump.
        cycle(1'b0, 8'hFF, 4'h0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0);
        check("t2_wrap", int'(PC), 0);
        cycle(1'b0, 8'h3C, 4'h0, 1'b0, 1'b1, 1'b0);
        check("t2_jump", int'(PC), 8'h3C);

        // Flags latch, hold, and ignored while idle.
        cycle(1'b1, 8'h00, 4'hA, 1'b1, 1'b1, 1'b0);
        check("t3_load", int'(NZVC), 4'hA);
        cycle(1'b1, 8'h00, 4'h5, 1'b0, 1'b1, 1'b0);
        check("t3_hold", int'(NZVC), 4'hA);
        cycle(1'b1, 8'h00, 4'h5, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 8'h00, 4'h5, 1'b1, 1'b0, 1'b0);
        check("t3_idle", int'(NZVC), 4'hA);

        // Single step with a held request.
        cycle(1'b1, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 8'h10, 4'h0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1);
        check("t4_one_step", int'(PC), 8'h11);
        check("t4_ack", int'(step_ack), 1);
        cycle(1'b1, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0); // run_en ignored in ACK path: request dropped
        check("t4_ack_drop", int'(step_ack), 0);
        cycle(1'b1, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1);
        check("t4_second_step", int'(PC), 8'h12);
        cycle(1'b1, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);

        // Saturation of the narrow counter.
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0);
        check("t6_saturate", int'(instr_count), CNT_MAX);

        // Asynchronous reset mid-run.
        cycle(1'b0, 8'h3F, 4'h0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h00, 4'h7, 1'b1, 1'b1, 1'b0);
        check("t5_pc40", int'(PC), 8'h40);
        do_reset();

        // Jump-to-self.
        cycle(1'b0, 8'h20, 4'h0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 8'h20, 4'h0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 8'h20, 4'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h20, 4'h0, 1'b0, 1'b1, 1'b1);
        check("t6_self_pc", int'(PC), 8'h20);
`ifdef HALT_DETECT_EN
        check("t6_halted", int'(halted), 1);
        check("t6_running", int'(running), 0);
        check("t6_count", int'(instr_count), 2);
`else
        check("t6_halted", int'(halted), 0);
        check("t6_count", int'(instr_count), 5);
`endif
        do_reset();

        // Randomised traffic with sticky control levels.
        re_r = 1'b0; sr_r = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) re_r = ~re_r;
            if ($urandom_range(0, 3) == 0) sr_r = ~sr_r;
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                cycle(($urandom_range(0, 3) != 0), 8'($urandom), 4'($urandom),
                      1'($urandom), re_r, sr_r);
            end
        end

        check("scoreboard_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
